// File: rtl/stft_pkg.sv
// rtl/stft_pkg.sv - shared FSM state type and default sizing for the STFT frame sequencer
package stft_pkg;

  typedef enum logic {ST_FILL, ST_STREAM} state_t;

  localparam int DEF_WORD_WIDTH    = 16;
  localparam int DEF_ADDRESS_WIDTH = 6;
  localparam int DEF_FRAME_LEN     = 32;
  localparam int DEF_HOP           = 16;

endpackage

// File: rtl/frame_ring_ram.sv
// rtl/frame_ring_ram.sv - simple dual-port sample ring: synchronous write, combinational read
module frame_ring_ram #(
  parameter int WORD_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0]    wr_data,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [WORD_WIDTH-1:0]    rd_data
);

  logic [WORD_WIDTH-1:0] mem [0:(1<<ADDRESS_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stft_frame_sequencer.sv
// rtl/stft_frame_sequencer.sv - overlapping-frame replay of a sample ring; optional sticky overrun via STFT_SEQ_OVERRUN_EN
module stft_frame_sequencer
  import stft_pkg::*;
#(
  parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int FRAME_LEN     = DEF_FRAME_LEN,
  parameter int HOP           = DEF_HOP
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  input  logic [WORD_WIDTH-1:0]    s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WORD_WIDTH-1:0]    m_data,
  output logic [ADDRESS_WIDTH-1:0] m_index,
  output logic                     m_last,
  output logic                     overrun,
  input  logic                     clr_overrun
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int AV_W  = ADDRESS_WIDTH + 1;
  localparam logic [AV_W-1:0]          DEPTH_V  = AV_W'(1 << ADDRESS_WIDTH);
  localparam logic [AV_W-1:0]          FRAME_V  = AV_W'(FRAME_LEN);
  localparam logic [AV_W-1:0]          HOP_V    = AV_W'(HOP);
  localparam logic [ADDRESS_WIDTH-1:0] HOP_A    = ADDRESS_WIDTH'(HOP);
  localparam logic [CNT_W-1:0]         LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_t                   state, state_nx;
  logic [ADDRESS_WIDTH-1:0] wr_ptr, frame_start, rd_addr;
  logic [AV_W-1:0]          avail, avail_nx;
  logic [CNT_W-1:0]         rd_cnt, rd_cnt_nx;
  logic                     valid_q, last_q, last_nx;
  logic                     wr_en, handshake, frame_done;
  logic [WORD_WIDTH-1:0]    rd_data;

  // A full ring drops the sample even if a frame retires in the same cycle.
  assign wr_en      = s_valid && (avail != DEPTH_V);
  assign handshake  = valid_q && m_ready;
  assign frame_done = handshake && (rd_cnt == LAST_CNT);
  assign rd_addr    = frame_start + ADDRESS_WIDTH'(rd_cnt);

  always_comb begin
    avail_nx  = avail + AV_W'(wr_en) - (frame_done ? HOP_V : '0);
    rd_cnt_nx = rd_cnt;
    if (handshake) rd_cnt_nx = frame_done ? '0 : rd_cnt + CNT_W'(1);
    state_nx = state;
    case (state)
      ST_FILL:   if (avail_nx >= FRAME_V) state_nx = ST_STREAM;
      ST_STREAM: if (frame_done && (avail_nx < FRAME_V)) state_nx = ST_FILL;
      default:   state_nx = ST_FILL;
    endcase
    last_nx = (state_nx == ST_STREAM) && (rd_cnt_nx == LAST_CNT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_FILL;
      wr_ptr      <= '0;
      frame_start <= '0;
      avail       <= '0;
      rd_cnt      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state   <= state_nx;
      avail   <= avail_nx;
      rd_cnt  <= rd_cnt_nx;
      valid_q <= (state_nx == ST_STREAM);
      last_q  <= last_nx;
      if (wr_en) wr_ptr <= wr_ptr + ADDRESS_WIDTH'(1);
      if (frame_done) frame_start <= frame_start + HOP_A;
    end
  end

  frame_ring_ram #(
    .WORD_WIDTH   (WORD_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_ring (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr),
    .wr_data(s_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  assign m_valid = valid_q;
  assign m_last  = last_q;
  assign m_index = ADDRESS_WIDTH'(rd_cnt);
  assign m_data  = valid_q ? rd_data : '0;

`ifdef STFT_SEQ_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk) begin
    if (!rst_n) overrun_q <= 1'b0;
    else if (s_valid && !wr_en) overrun_q <= 1'b1;
    else if (clr_overrun) overrun_q <= 1'b0;
  end

  assign overrun = overrun_q;
`else
  logic unused_clr;
  assign unused_clr = clr_overrun;
  assign overrun    = 1'b0;
`endif

endmodule

// File: doc/stft_frame_sequencer.md
# stft_frame_sequencer

Overlapping-frame sequencer for the STFT front end. Writes the incoming sample stream into a circular dual-port RAM and, once a full frame is buffered, replays FRAME_LEN consecutive samples to the FFT stage over a valid/ready stream. Successive frames start HOP samples apart, which gives the STFT overlap. Sits between the ADC sample interface and the windowing/FFT datapath.

## Interface
- WORD_WIDTH, 16, sample width
- ADDRESS_WIDTH, 6, ring address width; ring depth D = 2**ADDRESS_WIDTH
- FRAME_LEN, 32, samples per frame; power of two, FRAME_LEN + HOP <= D
- HOP, 16, frame advance in samples; 1 <= HOP <= FRAME_LEN

- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- s_valid  in  1  sample strobe; there is no backpressure toward the source
- s_data  in  WORD_WIDTH  sample
- m_valid  out  1  frame word valid
- m_ready  in  1  consumer accepts word
- m_data  out  WORD_WIDTH  frame word; forced to 0 when m_valid=0
- m_index  out  ADDRESS_WIDTH  position of the word within its frame, 0..FRAME_LEN-1
- m_last  out  1  high with the word at index FRAME_LEN-1
- overrun  out  1  sticky flag: a sample was dropped
- clr_overrun  in  1  clears overrun

## Operation
- Registers:
  - wr_ptr and frame_start, ADDRESS_WIDTH bits each, wrap mod D.
  - avail, ADDRESS_WIDTH+1 bits. Holds the number of samples written from frame_start onward. Range is 0..D.
  - rd_cnt, log2(FRAME_LEN) bits.
- Write path:
  - On s_valid with avail < D: write RAM[wr_ptr] <= s_data, then increment wr_ptr and avail.
  - On s_valid with avail == D: drop the sample and set overrun. wr_ptr and avail do not change.
- Read path: rd_addr = frame_start + rd_cnt (mod D). RAM read is combinational, so m_data = rd_data in the same cycle.
- FSM:
  - FILL: m_valid=0. Go to STREAM when avail >= FRAME_LEN.
  - STREAM: m_valid=1. On a handshake (m_valid & m_ready), rd_cnt increments. On the handshake with rd_cnt == FRAME_LEN-1:
    - rd_cnt <= 0;
    - frame_start += HOP;
    - avail -= HOP;
    - go to FILL, or stay in STREAM if the post-update avail >= FRAME_LEN.
- Simultaneous write and frame completion in one cycle: avail_next = avail + 1 - HOP.
- The overflow check uses avail before the update. A frame completing in the same cycle does not rescue the incoming sample.
- The frame currently streaming is never overwritten; this follows from avail <= D.
- clr_overrun clears the flag. If clr_overrun and an overrun event occur in the same cycle, set wins.

## Timing
- Reset values:
  - FSM = FILL;
  - wr_ptr = frame_start = avail = rd_cnt = 0;
  - m_valid = 0, m_last = 0, m_data = 0, m_index = 0, overrun = 0.
- Reset does not clear RAM contents. A reset mid-frame abandons the frame with no trailing m_last.
- Write latency: a sample written at edge N is readable from cycle N+1.
- First word: m_valid rises in the cycle after the edge that makes avail reach FRAME_LEN.
- Handshake:
  - Once m_valid is asserted, m_data, m_index and m_last stay stable until the handshake.
  - m_valid does not drop mid-frame.
- Back-to-back frames run with no idle cycle when avail permits.
- Throughput: one word per cycle while m_ready=1.

## Configuration
- STFT_SEQ_OVERRUN_EN defined:
  - overrun flag and clr_overrun are implemented as described above.
- Not defined:
  - overrun is tied to 0 and clr_overrun is ignored.
  - Drop behaviour on avail == D is unchanged: the sample is still discarded silently.

## Structure
- Shared package stft_pkg holds:
  - the FSM state enum (ST_FILL, ST_STREAM);
  - default constants for WORD_WIDTH, ADDRESS_WIDTH, FRAME_LEN, HOP.
- One sub-module: frame_ring_ram, a simple dual-port RAM (WORD_WIDTH x D) with a synchronous write port and a combinational read port.
- All pointer, avail and FSM logic stays in stft_frame_sequencer.

## Test plan
- Fill: m_ready=1, feed samples 1..32 -> one frame with m_data 1..32, m_index 0..31, m_last only on 32. m_valid first rises the cycle after sample 32 is written.
- Overlap: continue by feeding 33..48 -> second frame is 17..48. Feeding 49..64 gives a third frame, 33..64.
- Backpressure: random m_ready at 50% during the frame -> outputs held while m_ready=0. No word is skipped or repeated, and each frame is still 1..32 and then 17..48.
- Overrun (macro on): m_ready=0, feed 1..65 -> samples 1..64 stored, 65 dropped, overrun=1. After m_ready=1, the first frame is 1..32. Asserting clr_overrun then clears the flag. With the macro off, overrun stays 0.
- Simultaneous events: time a write on the m_last handshake at avail = FRAME_LEN -> avail_next = FRAME_LEN + 1 - HOP and the FSM returns to FILL. Also check that overrun set beats clr_overrun in the same cycle.
- Reset mid-frame: assert rst_n=0 at index 10 -> next cycle m_valid=0 and overrun=0. Refilling with 100..131 yields a frame of 100..131.
